kalman_host_seq: RTL
====================

Name: kalman_host_seq

Overview:
Host-side initiator that drives the kalman core across repeated filter steps. It does four things each step:
- collects a measurement vector z word-by-word from an upstream valid/ready stream;
- pulses the core's start;
- waits for done, and feeds x_out/P_out back as the next step's x/P;
- streams the updated state estimate out word-by-word.

It owns the filter state registers (x, P), so the core stays stateless between steps.

Parameters:
- TIMEOUT_CYCLES, 4096: max cycles waiting for kal_done before abort.
- P0_DIAG, 32'h0000_1000: Q20.12 value placed on the P diagonal at reset/init (1.0).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- init  in  1  reload x/P defaults and clear step_count
- size_state  in  3  state dimension, legal 1..6
- size_meas  in  3  measurement dimension, legal 1..4
- z_valid  in  1  measurement word valid
- z_ready  out  1  measurement word accepted when z_valid&z_ready
- z_data  in  32  measurement word, Q20.12
- kal_start  out  1  one-cycle start pulse to core
- kal_x_flat  out  192  current x to core
- kal_P_flat  out  1152  current P to core
- kal_z_flat  out  128  assembled z to core
- kal_x_out  in  192  core updated x
- kal_P_out  in  1152  core updated P
- kal_done  in  1  core completion
- est_valid  out  1  estimate word valid
- est_ready  in  1  downstream accepts estimate word
- est_data  out  32  estimate word x[i], Q20.12
- est_last  out  1  marks final estimate word of a step
- busy  out  1  high in START/WAIT/EMIT
- timeout_err  out  1  sticky; set on wait timeout
- step_count  out  16  completed steps, wraps at 16'hFFFF→0

Behaviour:
- Packing:
  - Word i occupies bits [32i+31:32i].
  - P is row-major, 6x6: element (r,c) is word r*6+c.
  - z word k = k-th accepted measurement word.
- Reset (rst_n=0 at clk edge):
  - state=COLLECT, x_reg=0, P_reg diagonal=P0_DIAG, off-diagonal=0, z_reg=0, counters=0.
  - All outputs 0 except kal_x_flat/kal_P_flat, which reflect the reset registers.
  - z_ready=0 while rst_n=0.
- Size latch:
  - size_state and size_meas are sampled when the first z word of a step is accepted, and held until the step returns to COLLECT.
  - 0 or out-of-range values clamp to the max (6 / 4).
- COLLECT:
  - z_ready=1 unless init=1.
  - Each handshake writes z word k and increments k.
  - Unwritten z slots are zero (z_reg is cleared on entry).
  - When word k=size_meas-1 is accepted → START the next cycle.
- START:
  - kal_start=1 for exactly one cycle.
  - Wait counter cleared.
  - → WAIT.
- WAIT:
  - kal_start=0; the counter increments each cycle.
  - kal_done=1 → latch x_reg←kal_x_out, P_reg←kal_P_out, go to EMIT. Registers show new values the next cycle.
  - If the counter reaches TIMEOUT_CYCLES without done: set timeout_err, leave x/P unchanged, return to COLLECT.
  - kal_done seen in any other state is ignored.
- EMIT:
  - est_valid=1, est_data=x_reg word i, est_last=(i==size_state-1).
  - Data is held stable while est_ready=0.
  - On the handshake of the last word: step_count+1, → COLLECT.
- Latency:
  - Last z accepted at cycle N → kal_start high at N+1.
  - kal_done at cycle D → est_valid high at D+1 with word 0.
  - Zero-stall output sustains one word per cycle.
- init:
  - Acts only in COLLECT with k=0.
  - Reloads x/P defaults, clears step_count and timeout_err.
  - z_ready=0 that cycle, so init beats a simultaneous z_valid.
  - init in other states or mid-collect is ignored.
- rst_n low in any state aborts immediately. kal_start is never issued after reset until a full z vector is collected.

Test Plan:
- Reset, then size_meas=4, z words 1,2,3,4 (×0x1000) back-to-back → kal_z_flat = {0x4000,0x3000,0x2000,0x1000}; kal_start is a single pulse at cycle N+1; kal_P_flat diagonal = 0x1000.
- Core model asserts kal_done 10 cycles after start with x_out words 0x1000..0x6000, size_state=6, est_ready=1 → 6 est words 0x1000..0x6000 on consecutive cycles, est_last on the 6th, step_count=1; next step's kal_x_flat equals the previous x_out.
- est_ready toggling 1,0,0,1 during EMIT → est_data/est_last held during stalls; no word lost or repeated.
- Core never asserts done, TIMEOUT_CYCLES=16 → timeout_err=1 at 16 wait cycles; state back in COLLECT with z_ready=1; x/P unchanged; step_count unchanged.
- size_meas=0 and size_state=7 → clamp to 4 and 6; size inputs changed mid-step → no effect until the next step.
- init with z_valid high in COLLECT → z_ready=0, x=0, P=P0 diagonal, step_count=0, timeout_err cleared. rst_n low during WAIT → next cycle COLLECT, outputs zero, a late kal_done is ignored.

Source files
------------

// File: rtl/kalman_host_seq_if.sv
// Bundle of the measurement stream, estimate stream and kalman core
// connections driven by the host sequencer.
interface kalman_host_seq_if;
  logic          z_valid;
  logic          z_ready;
  logic [31:0]   z_data;
  logic          kal_start;
  logic [191:0]  kal_x_flat;
  logic [1151:0] kal_P_flat;
  logic [127:0]  kal_z_flat;
  logic [191:0]  kal_x_out;
  logic [1151:0] kal_P_out;
  logic          kal_done;
  logic          est_valid;
  logic          est_ready;
  logic [31:0]   est_data;
  logic          est_last;

  // Sequencer side: accepts z, drives the core, emits estimates.
  modport master (
    input  z_valid, z_data, kal_x_out, kal_P_out, kal_done, est_ready,
    output z_ready, kal_start, kal_x_flat, kal_P_flat, kal_z_flat,
           est_valid, est_data, est_last
  );

  // Environment side: measurement source, kalman core and estimate sink.
  modport slave (
    output z_valid, z_data, kal_x_out, kal_P_out, kal_done, est_ready,
    input  z_ready, kal_start, kal_x_flat, kal_P_flat, kal_z_flat,
           est_valid, est_data, est_last
  );
endinterface

// File: rtl/kalman_host_seq.sv
// Host-side step sequencer for a stateless kalman core: gathers z, starts
// the core, folds x_out/P_out back into the state registers and streams x.
module kalman_host_seq #(
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] P0_DIAG        = 32'h0000_1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic [2:0]          size_state,
  input  logic [2:0]          size_meas,
  kalman_host_seq_if.master   bus,
  output logic                busy,
  output logic                timeout_err,
  output logic [15:0]         step_count
);
  localparam int DATA_W = 32;
  localparam int NX     = 6;
  localparam int NZ     = 4;

  typedef enum logic [1:0] {COLLECT, START, WAIT, EMIT} state_t;

  state_t                   state;
  logic [NX*DATA_W-1:0]     x_reg;
  logic [NX*NX*DATA_W-1:0]  p_reg;
  logic [NZ*DATA_W-1:0]     z_reg;
  logic [1:0]               z_idx;
  logic [2:0]               est_idx;
  logic [2:0]               sz_state_l;
  logic [2:0]               sz_meas_l;
  logic [31:0]              wait_cnt;
  logic                     start_q;
  logic [2:0]               meas_eff;
  logic                     meas_last;
  logic                     z_fire;
  logic                     est_fire;

  // Zero or out-of-range state dimension means "use the full 6".
  function automatic logic [2:0] clamp_state(input logic [2:0] s);
    return (s == 3'd0 || s > 3'd6) ? 3'd6 : s;
  endfunction

  // Zero or out-of-range measurement dimension means "use the full 4".
  function automatic logic [2:0] clamp_meas(input logic [2:0] s);
    return (s == 3'd0 || s > 3'd4) ? 3'd4 : s;
  endfunction

  // Initial covariance: P0_DIAG on the diagonal, zero elsewhere.
  function automatic logic [NX*NX*DATA_W-1:0] p_default();
    logic [NX*NX*DATA_W-1:0] p;
    p = '0;
    for (int r = 0; r < NX; r++) p[(r*(NX+1))*DATA_W +: DATA_W] = P0_DIAG;
    return p;
  endfunction

  // The first word of a step sees the live size input; later words use the latch.
  assign meas_eff  = (z_idx == 2'd0) ? clamp_meas(size_meas) : sz_meas_l;
  assign meas_last = ({1'b0, z_idx} == meas_eff - 3'd1);

  assign bus.z_ready    = rst_n && (state == COLLECT) && !init;
  assign z_fire         = bus.z_valid && bus.z_ready;
  assign bus.est_valid  = (state == EMIT);
  assign est_fire       = bus.est_valid && bus.est_ready;
  assign bus.est_data   = bus.est_valid ? x_reg[{est_idx, 5'b0} +: DATA_W] : '0;
  assign bus.est_last   = bus.est_valid && (est_idx == sz_state_l - 3'd1);
  assign bus.kal_start  = start_q;
  assign bus.kal_x_flat = x_reg;
  assign bus.kal_P_flat = p_reg;
  assign bus.kal_z_flat = z_reg;
  assign busy           = (state != COLLECT);

  // Step sequencer: collect z, pulse start, await done or timeout, emit x.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= COLLECT;
      x_reg       <= '0;
      p_reg       <= p_default();
      z_reg       <= '0;
      z_idx       <= '0;
      est_idx     <= '0;
      sz_state_l  <= '0;
      sz_meas_l   <= '0;
      wait_cnt    <= '0;
      start_q     <= 1'b0;
      timeout_err <= 1'b0;
      step_count  <= '0;
    end else begin
      start_q <= 1'b0;
      case (state)
        COLLECT: begin
          if (init && z_idx == 2'd0) begin
            x_reg       <= '0;
            p_reg       <= p_default();
            step_count  <= '0;
            timeout_err <= 1'b0;
          end else if (z_fire) begin
            z_reg[{z_idx, 5'b0} +: DATA_W] <= bus.z_data;
            if (z_idx == 2'd0) begin
              sz_state_l <= clamp_state(size_state);
              sz_meas_l  <= clamp_meas(size_meas);
            end
            if (meas_last) begin
              z_idx   <= '0;
              start_q <= 1'b1;
              state   <= START;
            end else begin
              z_idx <= z_idx + 2'd1;
            end
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (bus.kal_done) begin
            x_reg   <= bus.kal_x_out;
            p_reg   <= bus.kal_P_out;
            est_idx <= '0;
            state   <= EMIT;
          end else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            z_reg       <= '0;
            state       <= COLLECT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        EMIT: begin
          if (est_fire) begin
            if (bus.est_last) begin
              est_idx    <= '0;
              z_reg      <= '0;
              step_count <= step_count + 16'd1;
              state      <= COLLECT;
            end else begin
              est_idx <= est_idx + 3'd1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule
